// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the memory slave's state type, used by
// both the slave and any master model that talks to it.
package ahb_pkg;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'd0,
    TRANS_BUSY   = 2'd1,
    TRANS_NONSEQ = 2'd2,
    TRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    SIZE_BYTE = 3'd0,
    SIZE_HALF = 3'd1,
    SIZE_WORD = 3'd2
  } hsize_e;

  typedef enum logic {
    RESP_OKAY  = 1'b0,
    RESP_ERROR = 1'b1
  } hresp_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } slave_state_e;

  // Sizes above a word are never aligned, which folds the size check in.
  function automatic logic size_aligned(input logic [2:0] size, input logic [1:0] lo);
    case (size)
      SIZE_BYTE: return 1'b1;
      SIZE_HALF: return ~lo[0];
      SIZE_WORD: return lo == 2'b00;
      default:   return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_lanes(input logic [2:0] size, input logic [1:0] lo);
    case (size)
      SIZE_BYTE: return 4'b0001 << lo;
      SIZE_HALF: return 4'b0011 << {lo[1], 1'b0};
      default:   return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ahb_lite_mem_slave_if.sv
// AHB-Lite bus bundle between a master (or decoder) and the memory slave.
interface ahb_lite_mem_slave_if;

  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );

endinterface

// File: rtl/ahb_sram_array.sv
// DEPTH x 32 storage split into four byte lanes: clocked per-lane writes,
// combinational read of the same word address.
module ahb_sram_array #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          HCLK,
  input  logic [3:0]    byte_we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];

    always_ff @(posedge HCLK) begin
      if (byte_we[gi]) begin
        lane_mem[addr] <= wdata[8*gi +: 8];
      end
    end

    assign rdata[8*gi +: 8] = lane_mem[addr];
  end

endmodule

// File: rtl/ahb_lite_mem_slave.sv
// AHB-Lite word memory slave: address decode, wait-state / error FSM and
// byte-lane write control around an ahb_sram_array.
module ahb_lite_mem_slave
  import ahb_pkg::*;
#(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  ahb_lite_mem_slave_if.slave  bus
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [31:0] SPAN      = 32'(4 * DEPTH);
  localparam logic [3:0]  WAIT_LAST = 4'(WAIT_CYCLES);

  slave_state_e  state_reg, state_next;
  logic [3:0]    cnt_reg, cnt_next;
  logic          dp_valid_reg, dp_valid_next;
  logic          dp_write_reg, dp_write_next;
  logic [2:0]    dp_size_reg, dp_size_next;
  logic [AW+1:0] dp_addr_reg, dp_addr_next;

  logic [31:0] offset;
  logic        accept;
  logic        xfer_ok;
  logic        ready;
  logic        complete;
  logic [3:0]  lane_we;
  logic [31:0] rdata;
  logic        unused_ok;

  // Unsigned wrap makes addresses below BASE_ADDR land far out of range.
  assign offset  = bus.HADDR - BASE_ADDR;
  assign accept  = bus.HSEL && bus.HREADY && bus.HTRANS[1];
  assign xfer_ok = (offset < SPAN) && size_aligned(bus.HSIZE, bus.HADDR[1:0]);

  assign ready    = (state_reg == ST_WAIT) ? (cnt_reg == WAIT_LAST) : (state_reg != ST_ERR1);
  assign complete = dp_valid_reg && ready;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= 4'd0;
      dp_valid_reg <= 1'b0;
      dp_write_reg <= 1'b0;
      dp_size_reg  <= 3'd0;
      dp_addr_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      dp_valid_reg <= dp_valid_next;
      dp_write_reg <= dp_write_next;
      dp_size_reg  <= dp_size_next;
      dp_addr_reg  <= dp_addr_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    dp_valid_next = dp_valid_reg;
    dp_write_next = dp_write_reg;
    dp_size_next  = dp_size_reg;
    dp_addr_next  = dp_addr_reg;

    if (ready) begin
      // Any ready cycle ends the current data phase and may open the next one.
      state_next    = ST_IDLE;
      cnt_next      = 4'd0;
      dp_valid_next = 1'b0;
      if (accept) begin
        dp_write_next = bus.HWRITE;
        dp_size_next  = bus.HSIZE;
        dp_addr_next  = offset[AW+1:0];
        if (!xfer_ok) begin
          state_next = ST_ERR1;
        end else begin
          dp_valid_next = 1'b1;
          if (WAIT_CYCLES != 0) begin
            state_next = ST_WAIT;
          end
        end
      end
    end else if (state_reg == ST_WAIT) begin
      cnt_next = cnt_reg + 4'd1;
    end else if (state_reg == ST_ERR1) begin
      state_next = ST_ERR2;
    end
  end

  assign lane_we = (complete && dp_write_reg) ? byte_lanes(dp_size_reg, dp_addr_reg[1:0]) : 4'b0000;

  ahb_sram_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_sram (
    .HCLK    (HCLK),
    .byte_we (lane_we),
    .addr    (dp_addr_reg[AW+1:2]),
    .wdata   (bus.HWDATA),
    .rdata   (rdata)
  );

  assign bus.HREADYOUT = ready;
  assign bus.HRESP     = (state_reg == ST_ERR1 || state_reg == ST_ERR2) ? RESP_ERROR : RESP_OKAY;
  assign bus.HRDATA    = (complete && !dp_write_reg) ? rdata : 32'd0;

  assign unused_ok = ^{bus.HTRANS[0], bus.HBURST, bus.HPROT, bus.HMASTLOCK};

endmodule

// File: tb/tb_ahb_lite_mem_slave.sv
// Drives two slaves (zero-wait and three-wait) through one pipelined AHB
// master and checks every data phase against a byte-level memory model.
module tb_ahb_lite_mem_slave;
  import ahb_pkg::*;

  localparam int TB_DEPTH = 256;

  typedef struct packed {
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } item_t;

  logic        hclk;
  logic        hresetn;
  bit          tgt;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;

  int tests = 0;
  int fails = 0;

  ahb_lite_mem_slave_if bus0 ();
  ahb_lite_mem_slave_if bus3 ();

  assign bus0.HSEL = hsel & ~tgt;
  assign bus3.HSEL = hsel & tgt;
  assign bus0.HADDR = haddr;        assign bus3.HADDR = haddr;
  assign bus0.HTRANS = htrans;      assign bus3.HTRANS = htrans;
  assign bus0.HWRITE = hwrite;      assign bus3.HWRITE = hwrite;
  assign bus0.HSIZE = hsize;        assign bus3.HSIZE = hsize;
  assign bus0.HWDATA = hwdata;      assign bus3.HWDATA = hwdata;
  assign bus0.HBURST = 3'd0;        assign bus3.HBURST = 3'd0;
  assign bus0.HPROT = 4'd0;         assign bus3.HPROT = 4'd0;
  assign bus0.HMASTLOCK = 1'b0;     assign bus3.HMASTLOCK = 1'b0;
  assign bus0.HREADY = bus0.HREADYOUT;
  assign bus3.HREADY = bus3.HREADYOUT;

  ahb_lite_mem_slave #(.DEPTH(TB_DEPTH), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u_dut0 (
    .HCLK(hclk), .HRESETn(hresetn), .bus(bus0)
  );
  ahb_lite_mem_slave #(.DEPTH(TB_DEPTH), .WAIT_CYCLES(3), .BASE_ADDR(32'h0)) u_dut3 (
    .HCLK(hclk), .HRESETn(hresetn), .bus(bus3)
  );

  logic        obs_ready;
  logic        obs_resp;
  logic [31:0] obs_rdata;
  assign obs_ready = tgt ? bus3.HREADYOUT : bus0.HREADYOUT;
  assign obs_resp  = tgt ? bus3.HRESP     : bus0.HRESP;
  assign obs_rdata = tgt ? bus3.HRDATA    : bus0.HRDATA;

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  // Reference model: byte-addressed memory per slave plus "written" flags.
  logic [7:0] ref_b [2][4*TB_DEPTH];
  bit         ref_k [2][4*TB_DEPTH];

  item_t       q[$];
  item_t       pend;
  bit          pend_active;
  int          pend_waits;
  int          low_cycles;
  int          resp_cycles;
  int          last_waits;
  logic [31:0] last_rdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic item_t mk(input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                               input logic [31:0] ad, input logic [31:0] wd);
    item_t it;
    it.trans = tr; it.write = wr; it.size = sz; it.addr = ad; it.wdata = wd;
    return it;
  endfunction

  function automatic bit xfer_valid(input item_t it);
    if (it.size > 3'd2) return 1'b0;
    if (it.addr >= 32'(4 * TB_DEPTH)) return 1'b0;
    return (it.addr % (32'd1 << it.size)) == 32'd0;
  endfunction

  function automatic void ref_write(input int d, input item_t it);
    int unsigned a;
    for (int i = 0; i < (1 << it.size); i++) begin
      a = it.addr + 32'(i);
      ref_b[d][a] = it.wdata[8*(a%4) +: 8];
      ref_k[d][a] = 1'b1;
    end
  endfunction

  function automatic bit ref_read(input int d, input logic [31:0] addr, output logic [31:0] w);
    int unsigned base;
    bit k;
    base = (addr / 4) * 4;
    k = 1'b1;
    w = 32'd0;
    for (int i = 0; i < 4; i++) begin
      k = k & ref_k[d][base + 32'(i)];
      w[8*i +: 8] = ref_b[d][base + 32'(i)];
    end
    return k;
  endfunction

  task automatic drive_idle();
    hsel = 1'b0; htrans = TRANS_IDLE; hwrite = 1'b0; hsize = 3'd0; haddr = 32'd0;
  endtask

  // One bus cycle, evaluated at the falling edge.
  task automatic cycle();
    logic        rdy, resp, known;
    logic [31:0] rd, exp_w;
    bit          is_x, exp_err;
    int          exp_waits;
    string       kind;
    @(negedge hclk);
    rdy = obs_ready; resp = obs_resp; rd = obs_rdata;
    if (!rdy) low_cycles++;
    if (resp) resp_cycles++;
    if (!pend_active) begin
      check("idle_ready", 32'(rdy), 32'd1);
      check("idle_resp", 32'(resp), 32'd0);
      check("idle_rdata", rd, 32'd0);
    end else begin
      if (pend.write) hwdata = pend.wdata;
      is_x    = pend.trans[1];
      exp_err = is_x && !xfer_valid(pend);
      check("hresp", 32'(resp), 32'(exp_err));
      if (!rdy) begin
        pend_waits++;
        check("wait_rdata", rd, 32'd0);
        if (pend_waits > 40) begin
          fails++;
          $display("FAIL data_phase_timeout waits=%0d limit=40", pend_waits);
          $display("[TB] %0d tests run, %0d failed", tests, fails);
          $fatal(1, "data phase never completed");
        end
      end else begin
        exp_waits = !is_x ? 0 : (exp_err ? 1 : (tgt ? 3 : 0));
        check("waits", 32'(pend_waits), 32'(exp_waits));
        if (is_x && !exp_err && !pend.write) begin
          known = ref_read(int'(tgt), pend.addr, exp_w);
          if (known) check("rdata", rd, exp_w);
          last_rdata = rd;
        end else begin
          check("rdata_zero", rd, 32'd0);
          if (is_x && !exp_err) ref_write(int'(tgt), pend);
        end
        last_waits = pend_waits;
        kind = !is_x ? "IDLE/BUSY" : (exp_err ? "ERR" : (pend.write ? "WR" : "RD"));
        $display("[TB] dut%0d %-9s sz=%0d addr=%08h wd=%08h rd=%08h waits=%0d resp=%0d",
                 tgt ? 3 : 0, kind, pend.size, pend.addr, pend.wdata, rd, pend_waits, resp);
        pend_active = 1'b0;
      end
    end
    if (rdy) begin
      if (q.size() != 0) begin
        pend = q.pop_front();
        hsel = 1'b1; htrans = pend.trans; hwrite = pend.write;
        hsize = pend.size; haddr = pend.addr;
        pend_active = 1'b1;
        pend_waits  = 0;
      end else begin
        drive_idle();
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || pend_active) && n < 2000) begin
      cycle();
      n++;
    end
    check("drain_done", 32'(q.size() != 0 || pend_active), 32'd0);
    cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time_limit_reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] old_w;
    logic [31:0] r;
    logic [2:0]  sz;
    logic [1:0]  tr;
    int          n;
    bit          k;

    tgt = 1'b0; hwdata = 32'd0; pend_active = 1'b0;
    low_cycles = 0; resp_cycles = 0; last_rdata = 32'd0; last_waits = 0;
    drive_idle();
    hresetn = 1'b0;
    repeat (3) @(negedge hclk);
    check("rst_ready0", 32'(bus0.HREADYOUT), 32'd1);
    check("rst_resp0", 32'(bus0.HRESP), 32'd0);
    check("rst_rdata0", bus0.HRDATA, 32'd0);
    check("rst_ready3", 32'(bus3.HREADYOUT), 32'd1);
    check("rst_resp3", 32'(bus3.HRESP), 32'd0);
    check("rst_rdata3", bus3.HRDATA, 32'd0);
    hresetn = 1'b1;

    // Fill the first 64 words of both memories.
    for (int d = 0; d < 2; d++) begin
      tgt = (d == 1);
      for (int w = 0; w < 64; w++) q.push_back(mk(TRANS_NONSEQ, 1'b1, 3'd2, 32'(4*w), $urandom));
      drain();
    end

    // Zero-wait write then immediate readback.
    tgt = 1'b0; low_cycles = 0;
    q.push_back(mk(TRANS_NONSEQ, 1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF));
    q.push_back(mk(TRANS_NONSEQ, 1'b0, 3'd2, 32'h10, 32'h0));
    drain();
    check("w0_rdata", last_rdata, 32'hDEAD_BEEF);
    check("w0_no_wait", 32'(low_cycles), 32'd0);

    // Byte lane merge.
    q.push_back(mk(TRANS_NONSEQ, 1'b1, 3'd2, 32'h10, 32'h1122_3344));
    q.push_back(mk(TRANS_NONSEQ, 1'b1, 3'd0, 32'h11, 32'h5566_AA77));
    q.push_back(mk(TRANS_NONSEQ, 1'b0, 3'd2, 32'h10, 32'h0));
    drain();
    check("byte_merge", last_rdata, 32'h1122_AA44);

    // Errors leave memory untouched; also the last in-range word.
    resp_cycles = 0;
    q.push_back(mk(TRANS_NONSEQ, 1'b1, 3'd1, 32'h13, 32'hFFFF_FFFF));
    q.push_back(mk(TRANS_NONSEQ, 1'b0, 3'd2, 32'(4*TB_DEPTH), 32'h0));
    q.push_back(mk(TRANS_NONSEQ, 1'b0, 3'd2, 32'h10, 32'h0));
    drain();
    check("err_resp_cycles", 32'(resp_cycles), 32'd4);
    check("err_mem_kept", last_rdata, 32'h1122_AA44);
    q.push_back(mk(TRANS_NONSEQ, 1'b1, 3'd2, 32'(4*TB_DEPTH-4), 32'h0BAD_F00D));
    q.push_back(mk(TRANS_NONSEQ, 1'b0, 3'd2, 32'(4*TB_DEPTH-4), 32'h0));
    q.push_back(mk(TRANS_NONSEQ, 1'b1, 3'd2, 32'h12, 32'h1234_5678));
    q.push_back(mk(TRANS_NONSEQ, 1'b1, 3'd3, 32'h10, 32'h1234_5678));
    drain();
    check("top_word", last_rdata, 32'h0BAD_F00D);

    // Wait-state slave: word read takes exactly 3 low cycles.
    tgt = 1'b1;
    q.push_back(mk(TRANS_NONSEQ, 1'b1, 3'd2, 32'h20, 32'hA5A5_0F0F));
    drain();
    low_cycles = 0;
    q.push_back(mk(TRANS_NONSEQ, 1'b0, 3'd2, 32'h20, 32'h0));
    drain();
    check("w3_low_cycles", 32'(low_cycles), 32'd3);
    check("w3_waits", 32'(last_waits), 32'd3);
    check("w3_rdata", last_rdata, 32'hA5A5_0F0F);

    resp_cycles = 0;
    q.push_back(mk(TRANS_NONSEQ, 1'b1, 3'd1, 32'h13, 32'hFFFF_FFFF));
    q.push_back(mk(TRANS_NONSEQ, 1'b0, 3'd2, 32'(4*TB_DEPTH), 32'h0));
    drain();
    check("w3_err_resp_cycles", 32'(resp_cycles), 32'd4);

    // SEQ burst with a BUSY beat, both slaves.
    for (int d = 0; d < 2; d++) begin
      tgt = (d == 1);
      low_cycles = 0;
      q.push_back(mk(TRANS_NONSEQ, 1'b1, 3'd2, 32'h40, $urandom));
      q.push_back(mk(TRANS_SEQ,    1'b1, 3'd2, 32'h44, $urandom));
      q.push_back(mk(TRANS_BUSY,   1'b1, 3'd2, 32'h48, 32'h0));
      q.push_back(mk(TRANS_SEQ,    1'b1, 3'd2, 32'h48, $urandom));
      q.push_back(mk(TRANS_SEQ,    1'b1, 3'd2, 32'h4C, $urandom));
      drain();
      check("burst_low_cycles", 32'(low_cycles), d == 1 ? 32'd12 : 32'd0);
      for (int w = 0; w < 4; w++) q.push_back(mk(TRANS_NONSEQ, 1'b0, 3'd2, 32'(32'h40 + 4*w), 32'h0));
      drain();
    end

    // Random mixed traffic on both slaves.
    for (int d = 0; d < 2; d++) begin
      tgt = (d == 1);
      for (int i = 0; i < 80; i++) begin
        n = int'($urandom_range(0, 99));
        tr = (n < 10) ? TRANS_IDLE : (n < 18) ? TRANS_BUSY : (n < 60) ? TRANS_NONSEQ : TRANS_SEQ;
        sz = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
        n = int'($urandom_range(0, 9));
        r = (n == 0) ? 32'(32'h3F8 + $urandom_range(0, 15)) :
            (n == 1) ? 32'(32'hFFFF_FFF0 + $urandom_range(0, 15)) : 32'($urandom_range(0, 255));
        q.push_back(mk(tr, 1'($urandom_range(0, 1)), sz, r, $urandom));
      end
      drain();
    end

    // Reset in the middle of a waited write aborts it.
    tgt = 1'b1;
    k = ref_read(1, 32'h30, old_w);
    check("old_known", 32'(k), 32'd1);
    q.push_back(mk(TRANS_NONSEQ, 1'b1, 3'd2, 32'h30, ~old_w));
    n = 0;
    do begin
      cycle();
      n++;
    end while (!(pend_active && pend_waits >= 1) && n < 50);
    check("reached_wait", 32'(pend_active && pend_waits >= 1), 32'd1);
    hresetn = 1'b0;
    #1;
    check("mid_rst_ready", 32'(obs_ready), 32'd1);
    check("mid_rst_resp", 32'(obs_resp), 32'd0);
    check("mid_rst_rdata", obs_rdata, 32'd0);
    pend_active = 1'b0;
    drive_idle();
    @(negedge hclk);
    hresetn = 1'b1;
    q.push_back(mk(TRANS_NONSEQ, 1'b0, 3'd2, 32'h30, 32'h0));
    drain();
    check("abort_kept_old", last_rdata, old_w);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
